isram_fetch_seq: RTL and testbench

- Instruction-SRAM read sequencer that sits directly upstream of the engine's instruction register stage.
- On a request it reads two 5-word instruction groups from a single-port 48-bit I-SRAM: group 1 from base1, group 2 from base2.
- It assembles the ten words into shadow registers, then presents them atomically on eng_iMem_data1_1..5 / eng_iMem_data2_1..5. Downstream never sees a partially updated bundle.

---
 rtl/isram_fetch_seq.sv | 152 +++++++++++++++
 tb/tb_isram_fetch_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/isram_fetch_seq.sv
// Instruction-SRAM read sequencer: fetches two 5-word groups into shadow registers,
// then publishes all ten words to the engine's instruction-register inputs in one cycle.
module isram_fetch_seq #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 48,
  parameter int RD_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  // req_valid/req_ready: a request transfers on a clock edge where both are high;
  // req_valid while busy (req_ready low) is dropped, never queued.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_base1,
  input  logic [ADDR_W-1:0] req_base2,
  input  logic              flush,
  output logic              sram_ce,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [DATA_W-1:0] eng_iMem_data1_1,
  output logic [DATA_W-1:0] eng_iMem_data1_2,
  output logic [DATA_W-1:0] eng_iMem_data1_3,
  output logic [DATA_W-1:0] eng_iMem_data1_4,
  output logic [DATA_W-1:0] eng_iMem_data1_5,
  output logic [DATA_W-1:0] eng_iMem_data2_1,
  output logic [DATA_W-1:0] eng_iMem_data2_2,
  output logic [DATA_W-1:0] eng_iMem_data2_3,
  output logic [DATA_W-1:0] eng_iMem_data2_4,
  output logic [DATA_W-1:0] eng_iMem_data2_5,
  output logic              bundle_done,
  output logic              busy,
  output logic [1:0]        dbgState
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t            state, stateNext;
  logic [3:0]        idx, idxNext, nextIdx, offs, capIdx;
  logic [ADDR_W-1:0] base1, base2, addrNext;
  logic              ceNext, loadOut, flushAct, capEn, accept;
  logic [RD_LAT-1:0] tagVld;
  logic [3:0]        tagIdx [RD_LAT];
  logic [DATA_W-1:0] shadow [10];
  logic [DATA_W-1:0] shadowMerged [10];
  logic [DATA_W-1:0] engOut [10];

  assign dbgState = state;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    flushAct = flush && (state == ISSUE || state == DRAIN);
    accept   = (state == IDLE) && req_valid && req_ready;
    capIdx   = tagIdx[RD_LAT-1];
    capEn    = tagVld[RD_LAT-1] && !flushAct;
    // The word landing this cycle is merged in so DONE can publish it without an extra cycle.
    shadowMerged = shadow;
    if (capEn) shadowMerged[capIdx] = sram_rdata;
    nextIdx   = idx + 4'd1;
    offs      = (nextIdx < 4'd5) ? nextIdx : nextIdx - 4'd5;
    stateNext = state;
    idxNext   = idx;
    ceNext    = 1'b0;
    addrNext  = sram_addr;
    loadOut   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          stateNext = ISSUE;
          ceNext    = 1'b1;
          addrNext  = req_base1;
          idxNext   = 4'd0;
        end
      end
      ISSUE: begin
        if (flushAct) begin
          stateNext = IDLE;
        end else if (idx == 4'd9) begin
          stateNext = DRAIN;
        end else begin
          ceNext   = 1'b1;
          idxNext  = nextIdx;
          addrNext = ((nextIdx < 4'd5) ? base1 : base2) + ADDR_W'(offs);
        end
      end
      DRAIN: begin
        if (flushAct) begin
          stateNext = IDLE;
        end else if (capEn && capIdx == 4'd9) begin
          stateNext = DONE;
          loadOut   = 1'b1;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      idx         <= '0;
      base1       <= '0;
      base2       <= '0;
      sram_ce     <= 1'b0;
      sram_addr   <= '0;
      req_ready   <= 1'b0;
      busy        <= 1'b0;
      bundle_done <= 1'b0;
      tagVld      <= '0;
      for (int i = 0; i < RD_LAT; i++) tagIdx[i] <= '0;
      for (int i = 0; i < 10; i++) begin
        shadow[i] <= '0;
        engOut[i] <= '0;
      end
    end else begin
      idx         <= idxNext;
      sram_ce     <= ceNext;
      sram_addr   <= addrNext;
      req_ready   <= (stateNext == IDLE);
      busy        <= (stateNext != IDLE);
      bundle_done <= loadOut;
      if (accept) begin
        base1 <= req_base1;
        base2 <= req_base2;
      end
      // Tag of the read issued this cycle; a flush empties the whole pipeline.
      tagVld[0] <= sram_ce && !flushAct;
      tagIdx[0] <= idx;
      for (int i = RD_LAT - 1; i > 0; i--) begin
        tagVld[i] <= tagVld[i-1] && !flushAct;
        tagIdx[i] <= tagIdx[i-1];
      end
      shadow <= shadowMerged;
      if (loadOut) engOut <= shadowMerged;
    end
  end

  assign eng_iMem_data1_1 = engOut[0];
  assign eng_iMem_data1_2 = engOut[1];
  assign eng_iMem_data1_3 = engOut[2];
  assign eng_iMem_data1_4 = engOut[3];
  assign eng_iMem_data1_5 = engOut[4];
  assign eng_iMem_data2_1 = engOut[5];
  assign eng_iMem_data2_2 = engOut[6];
  assign eng_iMem_data2_3 = engOut[7];
  assign eng_iMem_data2_4 = engOut[8];
  assign eng_iMem_data2_5 = engOut[9];

endmodule

// File: tb/tb_isram_fetch_seq.sv
// Bench for isram_fetch_seq: an RD_LAT=1 and an RD_LAT=2 instance share one stimulus
// stream, each with its own SRAM model holding SRAM[a] = a*3.
module tb_isram_fetch_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [9:0]  req_base1 = '0;
  logic [9:0]  req_base2 = '0;
  logic        flush = 1'b0;

  logic        ready1, ce1, done1, busy1, ready2, ce2, done2, busy2;
  logic [9:0]  addr1, addr2;
  logic [1:0]  dbg1, dbg2;
  logic [47:0] rd1, rd2, s2;
  logic [47:0] e1 [10];
  logic [47:0] e2 [10];

  int nChecks = 0;
  int nFails  = 0;
  int cyc     = 0;

  typedef struct packed {
    logic [9:0]         b1;
    logic [9:0]         b2;
    logic [0:4][47:0]   d1;
    logic [0:4][47:0]   d2;
  } vec_t;
  vec_t        vecs [3];
  logic [47:0] prev [10];

  always #5 clock = ~clock;

  function automatic logic [47:0] memWord(input logic [9:0] a);
    return 48'(a) * 48'd3;
  endfunction

  // SRAM models; non-read cycles return a marker so stray captures are visible.
  always @(posedge clock) rd1 <= ce1 ? memWord(addr1) : 48'hBAD0_0000_0001;
  always @(posedge clock) begin
    s2  <= ce2 ? memWord(addr2) : 48'hBAD0_0000_0002;
    rd2 <= s2;
  end

  isram_fetch_seq #(.ADDR_W(10), .DATA_W(48), .RD_LAT(1)) dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .req_base1(req_base1), .req_base2(req_base2), .flush(flush),
    .sram_ce(ce1), .sram_addr(addr1), .sram_rdata(rd1),
    .eng_iMem_data1_1(e1[0]), .eng_iMem_data1_2(e1[1]), .eng_iMem_data1_3(e1[2]),
    .eng_iMem_data1_4(e1[3]), .eng_iMem_data1_5(e1[4]),
    .eng_iMem_data2_1(e1[5]), .eng_iMem_data2_2(e1[6]), .eng_iMem_data2_3(e1[7]),
    .eng_iMem_data2_4(e1[8]), .eng_iMem_data2_5(e1[9]),
    .bundle_done(done1), .busy(busy1), .dbgState(dbg1));

  isram_fetch_seq #(.ADDR_W(10), .DATA_W(48), .RD_LAT(2)) dut2 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
    .req_base1(req_base1), .req_base2(req_base2), .flush(flush),
    .sram_ce(ce2), .sram_addr(addr2), .sram_rdata(rd2),
    .eng_iMem_data1_1(e2[0]), .eng_iMem_data1_2(e2[1]), .eng_iMem_data1_3(e2[2]),
    .eng_iMem_data1_4(e2[3]), .eng_iMem_data1_5(e2[4]),
    .eng_iMem_data2_1(e2[5]), .eng_iMem_data2_2(e2[6]), .eng_iMem_data2_3(e2[7]),
    .eng_iMem_data2_4(e2[8]), .eng_iMem_data2_5(e2[9]),
    .bundle_done(done2), .busy(busy2), .dbgState(dbg2));

  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %0h expected %0h (time %0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [47:0] expWord(input int v, input int k);
    return (k < 5) ? vecs[v].d1[k] : vecs[v].d2[k-5];
  endfunction

  task automatic chkBundles(input string tag, input logic [47:0] x1 [10], input logic [47:0] x2 [10]);
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("%s lat1 word%0d", tag, k), 64'(e1[k]), 64'(x1[k]));
      chk($sformatf("%s lat2 word%0d", tag, k), 64'(e2[k]), 64'(x2[k]));
    end
  endtask

  // One complete fetch; cycle c is the period after the c-th edge counted from the accept edge.
  task automatic runFetch(input int v, input bit injectBusyReq, input bit flushAtReq);
    logic [47:0] nw [10];
    logic [9:0]  ea;
    for (int k = 0; k < 10; k++) nw[k] = expWord(v, k);
    req_base1 = vecs[v].b1;
    req_base2 = vecs[v].b2;
    req_valid = 1'b1;
    flush     = flushAtReq;
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) begin
        req_valid = 1'b0;
        flush     = 1'b0;
      end
      if (injectBusyReq && c == 5) begin
        req_valid = 1'b1;
        req_base1 = 10'h3A0;
        req_base2 = 10'h3B0;
      end
      if (injectBusyReq && c == 6) req_valid = 1'b0;
      if (c <= 10) begin
        ea = (c <= 5) ? vecs[v].b1 + 10'(c - 1) : vecs[v].b2 + 10'(c - 6);
        chk("ce1 issue", 64'(ce1), 64'd1);
        chk("addr1", 64'(addr1), 64'(ea));
        chk("ce2 issue", 64'(ce2), 64'd1);
        chk("addr2", 64'(addr2), 64'(ea));
      end else if (c == 11) begin
        chk("ce1 drain", 64'(ce1), 64'd0);
        chk("ce2 drain", 64'(ce2), 64'd0);
      end
      chk("done1", 64'(done1), 64'(c == 12));
      chk("done2", 64'(done2), 64'(c == 13));
      chk("busy1", 64'(busy1), 64'(c <= 12));
      chk("busy2", 64'(busy2), 64'(c <= 13));
      chk("ready1", 64'(ready1), 64'(c >= 13));
      chk("ready2", 64'(ready2), 64'(c >= 14));
      if (c == 12) chk("dbg1 done", 64'(dbg1), 64'd3);
      if (c == 13) chk("dbg2 done", 64'(dbg2), 64'd3);
      for (int k = 0; k < 10; k++) begin
        chk($sformatf("eng lat1 word%0d", k), 64'(e1[k]), 64'(c >= 12 ? nw[k] : prev[k]));
        chk($sformatf("eng lat2 word%0d", k), 64'(e2[k]), 64'(c >= 13 ? nw[k] : prev[k]));
      end
    end
    prev = nw;
  endtask

  initial begin
    vecs[0].b1 = 10'h010;
    vecs[0].b2 = 10'h200;
    vecs[0].d1 = {48'h30, 48'h33, 48'h36, 48'h39, 48'h3C};
    vecs[0].d2 = {48'h600, 48'h603, 48'h606, 48'h609, 48'h60C};
    vecs[1].b1 = 10'h3FE;
    vecs[1].b2 = 10'h005;
    vecs[1].d1 = {48'hBFA, 48'hBFD, 48'h0, 48'h3, 48'h6};
    vecs[1].d2 = {48'hF, 48'h12, 48'h15, 48'h18, 48'h1B};
    vecs[2].b1 = 10'h100;
    vecs[2].b2 = 10'h100;
    vecs[2].d1 = {48'h300, 48'h303, 48'h306, 48'h309, 48'h30C};
    vecs[2].d2 = {48'h300, 48'h303, 48'h306, 48'h309, 48'h30C};
    for (int k = 0; k < 10; k++) prev[k] = '0;

    // Reset state
    step();
    step();
    chk("reset ready1", 64'(ready1), 64'd0);
    chk("reset ready2", 64'(ready2), 64'd0);
    chk("reset ce1", 64'(ce1), 64'd0);
    chk("reset busy1", 64'(busy1), 64'd0);
    chk("reset done1", 64'(done1), 64'd0);
    chk("reset addr1", 64'(addr1), 64'd0);
    chk("reset dbg1", 64'(dbg1), 64'd0);
    chkBundles("reset", prev, prev);
    reset = 1'b0;
    step();
    chk("ready1 after reset", 64'(ready1), 64'd1);
    chk("ready2 after reset", 64'(ready2), 64'd1);

    // Basic fetch with a request injected while busy, then wrap-around, then base1==base2.
    for (int v = 0; v < 3; v++) runFetch(v, v == 0, 1'b0);

    // Flush in cycle 4 of a fetch.
    req_base1 = 10'h050;
    req_base2 = 10'h060;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush ce1", 64'(ce1), 64'd0);
    chk("flush ce2", 64'(ce2), 64'd0);
    chk("flush ready1", 64'(ready1), 64'd1);
    chk("flush ready2", 64'(ready2), 64'd1);
    chk("flush busy1", 64'(busy1), 64'd0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk("flush no done1", 64'(done1), 64'd0);
      chk("flush no done2", 64'(done2), 64'd0);
      chk("flush ce1 idle", 64'(ce1), 64'd0);
      chkBundles("flush hold", prev, prev);
    end
    runFetch(1, 1'b0, 1'b0);

    // Reset in cycle 7 of a fetch.
    req_base1 = vecs[0].b1;
    req_base2 = vecs[0].b2;
    req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    for (int c = 2; c <= 7; c++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) prev[k] = '0;
    chk("midreset ce1", 64'(ce1), 64'd0);
    chk("midreset ce2", 64'(ce2), 64'd0);
    chk("midreset busy1", 64'(busy1), 64'd0);
    chk("midreset busy2", 64'(busy2), 64'd0);
    chk("midreset ready1", 64'(ready1), 64'd0);
    chkBundles("midreset", prev, prev);
    step();
    chk("ready1 after midreset", 64'(ready1), 64'd1);
    for (int c = 0; c < 10; c++) begin
      step();
      chk("midreset no done1", 64'(done1), 64'd0);
      chk("midreset no done2", 64'(done2), 64'd0);
      chkBundles("midreset hold", prev, prev);
    end

    // flush together with req_valid in IDLE: the request is still accepted.
    runFetch(0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
